up_dn_counter_param: RTL

//  Parametrised up/down counter. Generalises the 5-bit up/down counter with:
//   - configurable width, bounds and step;
//   - saturate, wrap and ping-pong modes;
//   - count enable, direction and terminal-event outputs.

---
 rtl/up_dn_counter_param.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/up_dn_counter_param.sv
// Parametrised up/down counter with saturate, wrap and ping-pong modes.
// Counter, Dir and Wrap are registered; High/Low are decoded from Counter.
// All bound tests are done in WIDTH+1 bits so MAX_VAL+STEP never overflows.
module up_dn_counter_param #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 31,
    parameter int unsigned STEP    = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] IN,
    input  logic             Up,
    input  logic             Down,
    input  logic [1:0]       Mode,
    output logic [WIDTH-1:0] Counter,
    output logic             High,
    output logic             Low,
    output logic             Dir,
    output logic             Wrap
);

    localparam int unsigned XW = WIDTH + 1;

    localparam logic [XW-1:0] MIN_X  = XW'(MIN_VAL);
    localparam logic [XW-1:0] MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0] STEP_X = XW'(STEP);

    // Above UP_LIM a further +STEP would pass MAX_VAL; below DN_LIM a -STEP
    // would pass MIN_VAL. Both fit in XW bits given STEP <= MAX_VAL-MIN_VAL.
    localparam logic [XW-1:0] UP_LIM = MAX_X - STEP_X;
    localparam logic [XW-1:0] DN_LIM = MIN_X + STEP_X;

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    localparam logic [1:0] MODE_WRAP = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;

    logic [WIDTH-1:0] r_cnt;
    logic             r_dir;
    logic             r_wrap;

    logic [XW-1:0]    w_cnt_x;
    logic             w_at_top;
    logic             w_at_bot;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_dir_nxt;
    logic             w_wrap_nxt;

    // Clamp a load value into [MIN_VAL, MAX_VAL].
    function automatic logic [WIDTH-1:0] clamp_in(input logic [WIDTH-1:0] v);
        logic [XW-1:0] x;
        x = {1'b0, v};
        if (x < MIN_X) begin
            return MIN_W;
        end else if (x > MAX_X) begin
            return MAX_W;
        end
        return v;
    endfunction

    // Plain +STEP / -STEP; callers guarantee the result stays in range.
    function automatic logic [WIDTH-1:0] step_up(input logic [XW-1:0] c);
        return WIDTH'(c + STEP_X);
    endfunction

    function automatic logic [WIDTH-1:0] step_dn(input logic [XW-1:0] c);
        return WIDTH'(c - STEP_X);
    endfunction

    // Saturating steps: pin to the bound instead of overshooting it.
    function automatic logic [WIDTH-1:0] sat_up(input logic [XW-1:0] c);
        return (c > UP_LIM) ? MAX_W : step_up(c);
    endfunction

    function automatic logic [WIDTH-1:0] sat_dn(input logic [XW-1:0] c);
        return (c < DN_LIM) ? MIN_W : step_dn(c);
    endfunction

    assign w_cnt_x  = {1'b0, r_cnt};
    assign w_at_top = (w_cnt_x > UP_LIM);
    assign w_at_bot = (w_cnt_x < DN_LIM);

    // Next-state selection: Load beats stepping; Wrap defaults low every cycle.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_wrap_nxt = 1'b0;
        if (Load) begin
            w_cnt_nxt = clamp_in(IN);
            w_dir_nxt = 1'b1;
        end else if (En) begin
            case (Mode)
                MODE_WRAP: begin
                    if (Down) begin
                        if (w_at_bot) begin
                            w_cnt_nxt  = MAX_W;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = step_dn(w_cnt_x);
                        end
                    end else if (Up) begin
                        if (w_at_top) begin
                            w_cnt_nxt  = MIN_W;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = step_up(w_cnt_x);
                        end
                    end
                end
                MODE_PP: begin
                    if (r_dir) begin
                        if (w_at_top) begin
                            w_cnt_nxt  = MAX_W;
                            w_dir_nxt  = 1'b0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = step_up(w_cnt_x);
                        end
                    end else begin
                        if (w_at_bot) begin
                            w_cnt_nxt  = MIN_W;
                            w_dir_nxt  = 1'b1;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = step_dn(w_cnt_x);
                        end
                    end
                end
                default: begin
                    // Saturate (modes 00 and 11); Down has priority over Up.
                    if (Down) begin
                        w_cnt_nxt = sat_dn(w_cnt_x);
                    end else if (Up) begin
                        w_cnt_nxt = sat_up(w_cnt_x);
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset overriding everything else.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= MIN_W;
            r_dir  <= 1'b1;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dir  <= w_dir_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign Counter = r_cnt;
    assign High    = (r_cnt == MAX_W);
    assign Low     = (r_cnt == MIN_W);
    assign Dir     = r_dir;
    assign Wrap    = r_wrap;

endmodule
